gcl_scheduler: RTL and testbench

- Gate control list scheduler directly downstream of the list/array update unit.
- Captures gate control entries from the update unit's 32-entry GC write port and walks them in time slots of a programmed length.
- Drives an 8-bit per-queue gate-open vector to the TSN output queue arbiter.
- Starts on update-finish, stops on test-stop, restarts from entry 0 on every new update.

---
 rtl/gcl_scheduler.sv | 163 ++++++++++++++++
 tb/tb_gcl_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gcl_scheduler.sv
// Gate control list scheduler: stores GC entries from the update unit and
// walks them in fixed-length time slots, driving per-queue gate-open bits.
module gcl_scheduler #(
    parameter int              GC_DEPTH  = 32,
    parameter int              GATE_NUM  = 8,
    parameter logic [GATE_NUM-1:0] IDLE_GATE = 8'hFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_gcs_gc_wr,
    input  logic [4:0]          in_gcs_gc_addr,
    input  logic [127:0]        in_gcs_gc,
    input  logic                in_gcs_test_stop,
    input  logic [19:0]         in_gcs_time_slot_cycle,
    input  logic                in_gcs_update_finish,
    output logic [GATE_NUM-1:0] out_gcs_gate_state,
    output logic                out_gcs_gate_valid,
    output logic [4:0]          out_gcs_slot_idx,
    output logic                out_gcs_cycle_start,
    output logic [15:0]         out_gcs_cycle_cnt
);

    localparam int EW = GATE_NUM + 1;
    localparam logic [4:0] LAST_IDX = 5'(GC_DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t state, state_n;

    logic [EW-1:0]       gc_mem [0:GC_DEPTH-1];
    logic                upd_d;
    logic [19:0]         slot_cnt, slot_cnt_n;
    logic [19:0]         t_lat, t_lat_n;
    logic [GATE_NUM-1:0] gate, gate_n;
    logic                valid, valid_n;
    logic [4:0]          idx, idx_n;
    logic                start, start_n;
    logic [15:0]         cnt, cnt_n;

    logic [19:0]         t_in;
    logic                upd_rise;
    logic                boundary;
    logic [EW-1:0]       cur_entry;
    logic [4:0]          nxt_idx;
    logic [EW-1:0]       nxt_entry;
    logic [EW-1:0]       first_entry;
    logic                wrap;

    // Upper entry bits carry nothing this block uses.
    logic unused_gc_bits;
    assign unused_gc_bits = ^in_gcs_gc[127:EW];

    always_comb begin
        t_in        = (in_gcs_time_slot_cycle == 20'd0) ? 20'd1
                                                        : in_gcs_time_slot_cycle;
        upd_rise    = in_gcs_update_finish & ~upd_d;
        boundary    = (slot_cnt == t_lat - 20'd1);
        cur_entry   = gc_mem[idx];
        wrap        = cur_entry[GATE_NUM] | (idx == LAST_IDX);
        nxt_idx     = wrap ? 5'd0 : idx + 5'd1;
        nxt_entry   = gc_mem[nxt_idx];
        first_entry = gc_mem[0];
    end

    always_comb begin
        state_n    = state;
        slot_cnt_n = slot_cnt;
        t_lat_n    = t_lat;
        gate_n     = gate;
        valid_n    = valid;
        idx_n      = idx;
        start_n    = 1'b0;
        cnt_n      = cnt;
        unique case (state)
            S_IDLE: begin
                gate_n  = IDLE_GATE;
                valid_n = 1'b0;
                idx_n   = 5'd0;
                if (upd_rise & ~in_gcs_test_stop) begin
                    state_n    = S_RUN;
                    idx_n      = 5'd0;
                    gate_n     = first_entry[GATE_NUM-1:0];
                    slot_cnt_n = 20'd0;
                    t_lat_n    = t_in;
                    start_n    = 1'b1;
                    valid_n    = 1'b1;
                end
            end
            S_RUN: begin
                if (in_gcs_test_stop) begin
                    state_n    = S_IDLE;
                    gate_n     = IDLE_GATE;
                    valid_n    = 1'b0;
                    idx_n      = 5'd0;
                    cnt_n      = 16'd0;
                    slot_cnt_n = 20'd0;
                end else if (upd_rise) begin
                    idx_n      = 5'd0;
                    gate_n     = first_entry[GATE_NUM-1:0];
                    slot_cnt_n = 20'd0;
                    t_lat_n    = t_in;
                    start_n    = 1'b1;
                    valid_n    = 1'b1;
                    cnt_n      = 16'd0;
                end else if (boundary) begin
                    slot_cnt_n = 20'd0;
                    t_lat_n    = t_in;
                    idx_n      = nxt_idx;
                    gate_n     = nxt_entry[GATE_NUM-1:0];
                    if (wrap) begin
                        start_n = 1'b1;
                        cnt_n   = cnt + 16'd1;
                    end
                end else begin
                    slot_cnt_n = slot_cnt + 20'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            upd_d    <= 1'b0;
            slot_cnt <= 20'd0;
            t_lat    <= 20'd1;
            gate     <= IDLE_GATE;
            valid    <= 1'b0;
            idx      <= 5'd0;
            start    <= 1'b0;
            cnt      <= 16'd0;
            for (int i = 0; i < GC_DEPTH; i++) begin
                gc_mem[i] <= '0;
            end
        end else begin
            state    <= state_n;
            upd_d    <= in_gcs_update_finish;
            slot_cnt <= slot_cnt_n;
            t_lat    <= t_lat_n;
            gate     <= gate_n;
            valid    <= valid_n;
            idx      <= idx_n;
            start    <= start_n;
            cnt      <= cnt_n;
            if (in_gcs_gc_wr) begin
                gc_mem[in_gcs_gc_addr] <= in_gcs_gc[EW-1:0];
            end
        end
    end

    assign out_gcs_gate_state  = gate;
    assign out_gcs_gate_valid  = valid;
    assign out_gcs_slot_idx    = idx;
    assign out_gcs_cycle_start = start;
    assign out_gcs_cycle_cnt   = cnt;

endmodule

// File: tb/tb_gcl_scheduler.sv
// Scoreboard bench for gcl_scheduler: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_gcl_scheduler;

    logic         clk;
    logic         rst_n;
    logic         gc_wr;
    logic [4:0]   gc_addr;
    logic [127:0] gc;
    logic         test_stop;
    logic [19:0]  slot_len;
    logic         upd;
    logic [7:0]   gate_state;
    logic         gate_valid;
    logic [4:0]   slot_idx;
    logic         cycle_start;
    logic [15:0]  cycle_cnt;

    gcl_scheduler dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_gcs_gc_wr           (gc_wr),
        .in_gcs_gc_addr         (gc_addr),
        .in_gcs_gc              (gc),
        .in_gcs_test_stop       (test_stop),
        .in_gcs_time_slot_cycle (slot_len),
        .in_gcs_update_finish   (upd),
        .out_gcs_gate_state     (gate_state),
        .out_gcs_gate_valid     (gate_valid),
        .out_gcs_slot_idx       (slot_idx),
        .out_gcs_cycle_start    (cycle_start),
        .out_gcs_cycle_cnt      (cycle_cnt)
    );

    typedef struct {
        int          cyc;
        logic [30:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk) begin
        logic [30:0] got;
        exp_t        e;
        got = {gate_state, gate_valid, slot_idx, cycle_start, cycle_cnt};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                failures++;
                $display("FAIL %s: missed at cyc %0d (now %0d)", e.name, e.cyc, cyc);
            end else if (got !== e.val) begin
                failures++;
                $display("FAIL %s cyc=%0d: got gate=%h v=%b idx=%0d st=%b cnt=%0d, want gate=%h v=%b idx=%0d st=%b cnt=%0d",
                         e.name, cyc, got[30:23], got[22], got[21:17], got[16], got[15:0],
                         e.val[30:23], e.val[22], e.val[21:17], e.val[16], e.val[15:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic ex(input int c, input logic [7:0] g, input logic v,
                      input logic [4:0] i, input logic s, input logic [15:0] n,
                      input string nm);
        exp_t e;
        e.cyc  = c;
        e.val  = {g, v, i, s, n};
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr_entry(input logic [4:0] a, input logic [8:0] d);
        gc_wr   = 1'b1;
        gc_addr = a;
        gc      = {119'h5A5A_1234_DEAD_BEEF_0F0F_3C3C_777, d};
        tick(1);
        gc_wr   = 1'b0;
    endtask

    task automatic halt();
        ex(cyc + 1, 8'hFF, 1'b0, 5'd0, 1'b0, 16'd0, "halt");
        test_stop = 1'b1;
        tick(1);
        test_stop = 1'b0;
        upd       = 1'b0;
        tick(1);
    endtask

    task automatic load_list();
        wr_entry(5'd0, 9'h001);
        wr_entry(5'd1, 9'h002);
        wr_entry(5'd2, 9'h004);
        wr_entry(5'd3, 9'h108);
    endtask

    initial begin
        logic [7:0] lst [0:3];
        int c;
        lst[0] = 8'h01; lst[1] = 8'h02; lst[2] = 8'h04; lst[3] = 8'h08;
        rst_n = 1'b0; gc_wr = 1'b0; gc_addr = '0; gc = '0;
        test_stop = 1'b0; slot_len = 20'd1; upd = 1'b0;

        tick(2);
        ex(cyc, 8'hFF, 1'b0, 5'd0, 1'b0, 16'd0, "reset");
        rst_n = 1'b1;
        ex(cyc + 1, 8'hFF, 1'b0, 5'd0, 1'b0, 16'd0, "reset_idle");
        tick(1);

        // Cleared array: entries read as zero gates.
        c = cyc;
        ex(c + 1, 8'h00, 1'b1, 5'd0, 1'b1, 16'd0, "clr_e0");
        ex(c + 2, 8'h00, 1'b1, 5'd1, 1'b0, 16'd0, "clr_e1");
        upd = 1'b1;
        tick(2);
        halt();

        // Four-entry list, T=4.
        load_list();
        slot_len = 20'd4;
        c = cyc;
        for (int i = 0; i < 20; i++)
            ex(c + 1 + i, lst[(i / 4) % 4], 1'b1, 5'((i / 4) % 4),
               (i % 16) == 0, 16'(i / 16), "t4_walk");
        upd = 1'b1;
        tick(20);
        halt();

        // T=0 behaves as T=1.
        slot_len = 20'd0;
        c = cyc;
        for (int i = 0; i < 12; i++)
            ex(c + 1 + i, lst[i % 4], 1'b1, 5'(i % 4),
               (i % 4) == 0, 16'(i / 4), "t0_walk");
        upd = 1'b1;
        tick(12);
        halt();

        // No end flag: index wraps 31 -> 0.
        for (int a = 0; a < 32; a++) wr_entry(5'(a), 9'h0AA);
        slot_len = 20'd2;
        c = cyc;
        for (int i = 0; i < 66; i++)
            ex(c + 1 + i, 8'hAA, 1'b1, 5'((i / 2) % 32),
               (i % 64) == 0, 16'(i / 64), "full_wrap");
        upd = 1'b1;
        tick(66);
        halt();

        // Live T change and entry rewrite during RUN.
        load_list();
        slot_len = 20'd4;
        c = cyc;
        for (int k = 1; k <= 38; k++) begin
            if (k <= 12)
                ex(c + k, lst[(k - 1) / 4], 1'b1, 5'((k - 1) / 4), k == 1, 16'd0, "live_a");
            else if (k <= 20)
                ex(c + k, 8'h08, 1'b1, 5'd3, 1'b0, 16'd0, "live_slot3");
            else if (k <= 28)
                ex(c + k, 8'h01, 1'b1, 5'd0, k == 21, 16'd1, "live_slot0");
            else if (k <= 36)
                ex(c + k, 8'h02, 1'b1, 5'd1, 1'b0, 16'd1, "live_slot1");
            else
                ex(c + k, 8'hF0, 1'b1, 5'd2, 1'b0, 16'd1, "live_rewrite");
        end
        ex(c + 39, 8'hFF, 1'b0, 5'd0, 1'b0, 16'd0, "stop");
        ex(c + 40, 8'hFF, 1'b0, 5'd0, 1'b0, 16'd0, "stop_idle");
        ex(c + 41, 8'h01, 1'b1, 5'd0, 1'b1, 16'd0, "restart");
        ex(c + 42, 8'h01, 1'b1, 5'd0, 1'b0, 16'd0, "restart_hold");
        ex(c + 43, 8'h01, 1'b1, 5'd0, 1'b0, 16'd0, "pre_rst");
        ex(c + 44, 8'hFF, 1'b0, 5'd0, 1'b0, 16'd0, "async_rst");
        ex(c + 46, 8'hFF, 1'b0, 5'd0, 1'b0, 16'd0, "post_rst");
        ex(c + 47, 8'h00, 1'b1, 5'd0, 1'b1, 16'd0, "rst_arr_clr");
        upd = 1'b1;
        tick(9);
        slot_len = 20'd8;
        gc_wr = 1'b1; gc_addr = 5'd2; gc = {119'h0, 9'h0F0};
        tick(1);
        gc_wr = 1'b0;
        tick(28);
        test_stop = 1'b1;
        tick(1);
        test_stop = 1'b0;
        upd = 1'b0;
        tick(1);
        upd = 1'b1;
        tick(4);
        #1;
        rst_n = 1'b0;
        upd = 1'b0;
        tick(1);
        rst_n = 1'b1;
        slot_len = 20'd1;
        tick(1);
        upd = 1'b1;
        tick(1);
        halt();

        tick(3);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover: %0d expectations unchecked, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
